// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory wait freezes,
// with saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_reg_we,
    input  logic             idex_mem_to_reg,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             exmem_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'b00,
        ACT_FREEZE = 2'b01,
        ACT_FLUSH  = 2'b10,
        ACT_BUBBLE = 2'b11
    } action_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic    load_use_s;
    logic    mem_busy_s;
    action_t action_s;
    logic    pc_we_s, ifid_we_s, exmem_we_s, ifid_flush_s, idex_flush_s;

    // Hazard detection and per-state action selection (encoding 11 falls into the RUN branch).
    always_comb begin
        load_use_s = idex_reg_we && idex_mem_to_reg && (idex_rd != 5'd0) &&
                     ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                      (ifid_use_rs2 && (idex_rd == ifid_rs2)));
        mem_busy_s = dmem_req && !dmem_ready;
        action_s   = ACT_NONE;
        state_d    = RUN;
        case (state_q)
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    action_s = ACT_FREEZE;
                end else if (branch_taken) begin
                    action_s = ACT_FLUSH;
                end else if (load_use_s) begin
                    action_s = ACT_BUBBLE;
                end else begin
                    action_s = ACT_NONE;
                end
            end
            LU_STALL: begin
                if (mem_busy_s) begin
                    action_s = ACT_FREEZE;
                end else if (branch_taken) begin
                    action_s = ACT_FLUSH;
                end else begin
                    action_s = ACT_NONE;
                end
            end
            default: begin
                if (mem_busy_s) begin
                    action_s = ACT_FREEZE;
                end else if (branch_taken) begin
                    action_s = ACT_FLUSH;
                end else if (load_use_s) begin
                    action_s = ACT_BUBBLE;
                end else begin
                    action_s = ACT_NONE;
                end
            end
        endcase
        case (action_s)
            ACT_FREEZE: state_d = MEM_WAIT;
            ACT_BUBBLE: state_d = LU_STALL;
            default:    state_d = RUN;
        endcase
    end

    // Pipeline control outputs; reset forces everything frozen and flushed.
    always_comb begin
        pc_we_s      = 1'b1;
        ifid_we_s    = 1'b1;
        exmem_we_s   = 1'b1;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        if (rst) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            exmem_we_s   = 1'b0;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else begin
            case (action_s)
                ACT_FREEZE: begin
                    pc_we_s    = 1'b0;
                    ifid_we_s  = 1'b0;
                    exmem_we_s = 1'b0;
                end
                ACT_FLUSH: begin
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                end
                ACT_BUBBLE: begin
                    pc_we_s      = 1'b0;
                    ifid_we_s    = 1'b0;
                    idex_flush_s = 1'b1;
                end
                default: begin
                    pc_we_s = 1'b1;
                end
            endcase
        end
    end

    // Performance counters, memory-wait counter and sticky timeout.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        if (!pc_we_s && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if ((action_s == ACT_FLUSH) && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end else begin
            flush_count_d = flush_count_q;
        end
        if (action_s == ACT_FREEZE) begin
            if (state_q != MEM_WAIT) begin
                wait_cnt_d = {WAIT_W{1'b0}};
            end else begin
                if (wait_cnt_q != WAIT_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
                if (wait_cnt_d == WAIT_LIMIT) begin
                    mem_timeout_d = 1'b1;
                end else begin
                    mem_timeout_d = mem_timeout_q;
                end
            end
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            stall_cycles_q <= {CNT_W{1'b0}};
            flush_count_q  <= {CNT_W{1'b0}};
            wait_cnt_q     <= {WAIT_W{1'b0}};
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign pc_we        = pc_we_s;
    assign ifid_we      = ifid_we_s;
    assign exmem_we     = exmem_we_s;
    assign ifid_flush   = ifid_flush_s;
    assign idex_flush   = idex_flush_s;
    assign state        = state_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign mem_timeout  = mem_timeout_q;

endmodule
